mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one Multiplexer_81-style 8:1 selector among eight requesters. It samples a request vector, grants exactly one requester at a time, and drives the 3-bit mux select to the granted index. A grant tenure counter forces rotation when other requesters wait, so no single source can hog the shared mux output. It sits directly in front of the mux select input; the mux data inputs are driven by the requesters themselves.

---
 rtl/mux8_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_arbiter
// Purpose  : Round-robin arbiter driving the select of a shared 8:1 mux, with
//            tenure-limited grants. Optional macro MUX_ARB_LOCK_EN adds 'lock'.
// Revision : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       gnt_chg
);

  localparam logic [0:0]        c_IDLE    = 1'b0;
  localparam logic [0:0]        c_GRANT   = 1'b1;
  localparam logic [HOLD_W-1:0] c_TEN_MAX = HOLD_W'(HOLD_MAX - 1);

  logic [0:0]        r_state, w_state_nx;
  logic [7:0]        r_gnt,   w_gnt_nx;
  logic [2:0]        r_sel,   w_sel_nx;
  logic [2:0]        r_ptr,   w_ptr_nx;
  logic [HOLD_W-1:0] r_ten,   w_ten_nx;
  logic              r_chg,   w_chg_nx;

  logic [7:0] w_vec;
  logic [2:0] w_start;
  logic [2:0] w_idx;
  logic [2:0] w_win;
  logic       w_found;
  logic       w_lock;
  logic       w_cur;
  logic       w_contend;
  logic       w_rel;

`ifdef MUX_ARB_LOCK_EN
  assign w_lock = lock;
`else
  assign w_lock = 1'b0;
`endif

  assign w_cur     = |(req & r_gnt);
  assign w_contend = |(req & ~r_gnt);
  assign w_rel     = !w_cur || (!w_lock && (r_ten == c_TEN_MAX) && w_contend);

  // One shared search: from ptr in IDLE, from g+1 with g masked on release.
  always_comb begin
    w_vec   = (r_state == c_GRANT) ? (req & ~r_gnt) : req;
    w_start = (r_state == c_GRANT) ? (r_sel + 3'd1) : r_ptr;
    w_found = 1'b0;
    w_win   = 3'd0;
    w_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_idx = w_start + 3'(i);
      if (!w_found && w_vec[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_gnt   <= 8'd0;
      r_sel   <= 3'd0;
      r_ptr   <= 3'd0;
      r_ten   <= '0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_sel   <= w_sel_nx;
      r_ptr   <= w_ptr_nx;
      r_ten   <= w_ten_nx;
      r_chg   <= w_chg_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_sel_nx   = r_sel;
    w_ptr_nx   = r_ptr;
    w_ten_nx   = r_ten;
    w_chg_nx   = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_found) begin
          w_state_nx = c_GRANT;
          w_gnt_nx   = 8'd1 << w_win;
          w_sel_nx   = w_win;
          w_ten_nx   = '0;
          w_chg_nx   = 1'b1;
        end
      end
      c_GRANT: begin
        if (w_rel) begin
          w_ptr_nx = r_sel + 3'd1;
          if (w_found) begin
            w_gnt_nx = 8'd1 << w_win;
            w_sel_nx = w_win;
            w_ten_nx = '0;
            w_chg_nx = 1'b1;
          end else begin
            w_state_nx = c_IDLE;
            w_gnt_nx   = 8'd0;
          end
        end else if (!w_lock && (r_ten != c_TEN_MAX)) begin
          w_ten_nx = r_ten + 1'b1;
        end
      end
      default: begin
        w_state_nx = c_IDLE;
        w_gnt_nx   = 8'd0;
      end
    endcase
  end

  always_comb begin
    gnt     = r_gnt;
    sel     = r_sel;
    busy    = (r_state == c_GRANT);
    gnt_chg = r_chg;
  end

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// Testbench for mux8_rr_arbiter: behavioural model compared every cycle,
// directed literal checks, then randomized traffic with occasional resets.
module tb_mux8_rr_arbiter;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       lock;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       gnt_chg;

  int total = 0;
  int bad   = 0;

  mux8_rr_arbiter #(.HOLD_MAX(HM), .HOLD_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
`ifdef MUX_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .gnt_chg (gnt_chg)
  );

  always #5 clk = ~clk;

  // Reference model state: granted index, pointer, tenure as plain integers.
  int m_busy, m_g, m_ptr, m_ten, m_sel, m_chg;

  function automatic int search(input logic [7:0] v, input int st);
    for (int k = 0; k < 8; k++) begin
      if (v[(st + k) % 8]) return (st + k) % 8;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_g = 0; m_ptr = 0; m_ten = 0; m_sel = 0; m_chg = 0;
    end else begin
      int w, lk;
      logic [7:0] others;
      lk = 0;
`ifdef MUX_ARB_LOCK_EN
      lk = int'(lock);
`endif
      m_chg = 0;
      if (m_busy == 0) begin
        w = search(req, m_ptr);
        if (w >= 0) begin
          m_busy = 1; m_g = w; m_sel = w; m_ten = 0; m_chg = 1;
        end
      end else begin
        others = req & ~(8'(1) << m_g);
        if (!req[m_g] || (lk == 0 && m_ten == HM - 1 && others != 0)) begin
          m_ptr = (m_g + 1) % 8;
          w = search(others, m_ptr);
          if (w >= 0) begin
            m_g = w; m_sel = w; m_ten = 0; m_chg = 1;
          end else begin
            m_busy = 0;
          end
        end else if (lk == 0 && m_ten < HM - 1) begin
          m_ten = m_ten + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] eg;
    eg = (m_busy != 0) ? (8'(1) << m_g) : 8'd0;
    total++;
    if (gnt !== eg || sel !== 3'(m_sel) || busy !== (m_busy != 0) || gnt_chg !== (m_chg != 0)) begin
      bad++;
      $display("FAIL model t=%0t: got gnt=%h sel=%0d busy=%0b chg=%0b, want gnt=%h sel=%0d busy=%0d chg=%0d",
               $time, gnt, sel, busy, gnt_chg, eg, m_sel, m_busy, m_chg);
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    lock  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_gnt", gnt, 8'h00);
    chk("idle_busy", 8'(busy), 8'h00);

    // Single requester
    req = 8'h20;
    @(negedge clk);
    chk("single_gnt", gnt, 8'h20);
    chk("single_sel", 8'(sel), 8'd5);
    chk("single_chg", 8'(gnt_chg), 8'd1);
    @(negedge clk);
    chk("single_chg_pulse", 8'(gnt_chg), 8'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("single_hold", gnt, 8'h20);
    end
    req = 8'h00;
    @(negedge clk);
    chk("drop_gnt", gnt, 8'h00);
    chk("drop_busy", 8'(busy), 8'h00);
    chk("drop_sel", 8'(sel), 8'd5);

    // Wrap and masking: ptr=6 now
    req = 8'h05;
    @(negedge clk);
    chk("wrap_first", gnt, 8'h01);
    repeat (3) begin
      @(negedge clk);
      chk("wrap_hold", gnt, 8'h01);
    end
    @(negedge clk);
    chk("wrap_second", gnt, 8'h04);
    req = 8'h00;
    @(negedge clk);

    // Rotation
    do_reset();
    req = 8'h81;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        chk("rotate", gnt, (r % 2 == 0) ? 8'h01 : 8'h80);
      end
    end

    // Voluntary handover
    do_reset();
    req = 8'h08;
    @(negedge clk);
    chk("vol_gnt3", gnt, 8'h08);
    req = 8'h18;
    @(negedge clk);
    chk("vol_hold3", gnt, 8'h08);
    req = 8'h10;
    @(negedge clk);
    chk("vol_gnt4", gnt, 8'h10);
    chk("vol_sel4", 8'(sel), 8'd4);
    chk("vol_chg", 8'(gnt_chg), 8'd1);

    // Asynchronous reset mid-grant
    req = 8'hFF;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", gnt, 8'h00);
    chk("async_sel", 8'(sel), 8'h00);
    chk("async_busy", 8'(busy), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h00;
    @(negedge clk);
    chk("post_rst_gnt", gnt, 8'h00);

`ifdef MUX_ARB_LOCK_EN
    req = 8'h03;
    repeat (4) @(negedge clk);
    lock = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("lock_hold", gnt, 8'h01);
    end
    lock = 1'b0;
    @(negedge clk);
    chk("lock_release", gnt, 8'h02);
    req = 8'h00;
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
`ifdef MUX_ARB_LOCK_EN
      if ($urandom_range(0, 7) == 0) lock = ~lock;
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
